mips_bus_dram: RTL and testbench

- Word-addressed data-memory responder for the bus-variant MIPS CPU: the target end of the CPU's data-side read/write interface.
- Uses an Avalon-style handshake with address, read, write, writedata, byteenable, waitrequest and readdata.
- Inserts a configurable number of wait states, so the CPU's stall logic is exercised.
- Provides a combinational inspection port that the bench uses to check memory after the CPU finishes, without muxing the CPU bus.

---
 rtl/mips_bus_dram.sv | 142 ++++++++++++++
 tb/tb_mips_bus_dram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_dram.sv
// Word-addressed data-memory responder with an Avalon-style handshake and wait states.
// Define MIPS_BUS_DRAM_RANDOM_WAIT_EN to draw per-transfer wait states from a 16-bit LFSR.
module mips_bus_dram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic [31:0] tb_address,
  output logic [31:0] tb_readdata,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [3:0]  waits;
  logic        req, complete;
  logic [31:0] off, tb_off, rd_word;
  logic        acc_ok, tb_ok, misaligned;
  logic [31:0] mem [DEPTH_WORDS];

  // Memory image at time 0; contents are never touched by reset.
  initial begin
    for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] = 32'h0;
  end

  assign req        = read | write;
  assign off        = address - BASE_ADDR;
  assign tb_off     = tb_address - BASE_ADDR;
  assign acc_ok     = (address >= BASE_ADDR) &&
                      ({2'b00, off} < ({2'b00, DEPTH_WORDS} << 2));
  assign tb_ok      = (tb_address >= BASE_ADDR) &&
                      ({2'b00, tb_off} < ({2'b00, DEPTH_WORDS} << 2));
  assign misaligned = (address[1:0] != 2'b00);

`ifdef MIPS_BUS_DRAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign waits = 4'(32'(lfsr_q[3:0]) % (WAIT_CYCLES + 1));
`else
  assign waits = 4'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waitrequest = 1'b0;
    complete    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (waits == 4'd0) begin
            complete = 1'b1;
          end else begin
            waitrequest = 1'b1;
            cnt_d       = waits - 4'd1;
            state_d     = StWait;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;  // request withdrawn: abort without side effects
        end else if (cnt_q != 4'd0) begin
          waitrequest = 1'b1;
          cnt_d       = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // While reset is held the responder stalls any request and completes nothing.
    if (!reset) begin
      waitrequest = req;
      complete    = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (complete && ((read && write) || misaligned || !acc_ok)) err_d = 1'b1;
  end

  assign err = err_q;

  always_comb begin
    rd_word  = mem[off[AW+1:2]];
    readdata = 32'h0;
    if (complete && read && !write && acc_ok) begin
      for (int i = 0; i < 4; i++) begin
        readdata[8*i +: 8] = byteenable[i] ? rd_word[8*i +: 8] : 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (complete && write && acc_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[off[AW+1:2]][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  assign tb_readdata = tb_ok ? mem[tb_off[AW+1:2]] : 32'h0;

endmodule

// File: tb/tb_mips_bus_dram.sv
// Bench for mips_bus_dram: three instances (2, 0 and 3 wait states) checked against a
// byte-addressed reference memory with directed and random transfers.
module tb_mips_bus_dram;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NI    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address [NI];
  logic        read [NI];
  logic        write [NI];
  logic [31:0] writedata [NI];
  logic [3:0]  byteenable [NI];
  logic        waitrequest [NI];
  logic [31:0] readdata [NI];
  logic [31:0] tb_address [NI];
  logic [31:0] tb_readdata [NI];
  logic        err [NI];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  mref [NI][DEPTH*4];
  logic        err_m [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < int'(NI); g++) begin : g_dut
    mips_bus_dram #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (32'h0),
      .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 3)),
      .INIT_FILE  ("")
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address[g]),
      .read       (read[g]),
      .write      (write[g]),
      .writedata  (writedata[g]),
      .byteenable (byteenable[g]),
      .waitrequest(waitrequest[g]),
      .readdata   (readdata[g]),
      .tb_address (tb_address[g]),
      .tb_readdata(tb_readdata[g]),
      .err        (err[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < 4 * DEPTH;
  endfunction

  // Little-endian lane order: lane i holds the byte at word address + i.
  function automatic logic [31:0] mword(input int k, input logic [31:0] a);
    int unsigned b;
    if (!in_rng(a)) return 32'h0;
    b = {a[31:2], 2'b00};
    return {mref[k][b+3], mref[k][b+2], mref[k][b+1], mref[k][b]};
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input int k, input logic [31:0] a, input string tag);
    tb_address[k] = a;
    #1;
    chk(tag, tb_readdata[k], mword(k, a));
  endtask

  task automatic xfer(input int k, input logic [31:0] a, input logic r, input logic w,
                      input logic [31:0] d, input logic [3:0] be, input string tag);
    int          waits;
    bit          done;
    logic [31:0] exp_rd;
    int unsigned b;
    waits  = 0;
    done   = 0;
    exp_rd = (r && !w && in_rng(a)) ? (mword(k, a) & lanes(be)) : 32'h0;
    address[k] = a; read[k] = r; write[k] = w; writedata[k] = d; byteenable[k] = be;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (waitrequest[k] === 1'b0) begin
        done = 1;
        chk({tag, ".rdata"}, readdata[k], exp_rd);
      end else begin
        waits++;
        if (c == 0) chk({tag, ".rd_idle"}, readdata[k], 32'h0);
      end
      @(posedge clk);
      #1;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".waits"}, 32'(waits), 32'(wc(k)));
    if (w && in_rng(a)) begin
      b = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++) if (be[i]) mref[k][b+i] = d[8*i +: 8];
    end
    if ((r && w) || (a[1:0] != 2'b00) || !in_rng(a)) err_m[k] = 1'b1;
    read[k] = 1'b0; write[k] = 1'b0;
    chk({tag, ".err"}, 32'(err[k]), 32'(err_m[k]));
    peek(k, a, {tag, ".tb"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          sel;
    for (int k = 0; k < int'(NI); k++) begin
      for (int i = 0; i < int'(DEPTH*4); i++) mref[k][i] = 8'h00;
      err_m[k] = 1'b0;
      address[k] = 32'h0; read[k] = 1'b0; write[k] = 1'b0;
      writedata[k] = 32'h0; byteenable[k] = 4'h0; tb_address[k] = 32'h0;
    end
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < int'(NI); k++) begin
      chk("rst.waitreq", 32'(waitrequest[k]), 32'd0);
      chk("rst.rdata", readdata[k], 32'h0);
      chk("rst.err", 32'(err[k]), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Write then read with two wait states.
    xfer(0, 32'h100, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, "wr100");
    xfer(0, 32'h100, 1'b1, 1'b0, 32'h0, 4'hF, "rd100");
    chk("rd100.const", tb_readdata[0], 32'hDEADBEEF);

    // Partial write.
    xfer(0, 32'h104, 1'b0, 1'b1, 32'h11223344, 4'hF, "wr104");
    xfer(0, 32'h104, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, "pw104");
    chk("pw104.const", tb_readdata[0], 32'h11BB33DD);
    chk("pw104.err0", 32'(err[0]), 32'd0);

    // Zero wait states.
    xfer(1, 32'h0, 1'b1, 1'b0, 32'h0, 4'hF, "zw.rd0");

    // Abort after one cycle of a three-wait-state write.
    xfer(2, 32'h108, 1'b0, 1'b1, 32'h12345678, 4'hF, "ab.pre");
    address[2] = 32'h108; write[2] = 1'b1; writedata[2] = 32'h5; byteenable[2] = 4'hF;
    @(negedge clk);
    chk("ab.wr_hi", 32'(waitrequest[2]), 32'd1);
    @(posedge clk); #1;
    write[2] = 1'b0;
    @(negedge clk);
    chk("ab.wr_lo", 32'(waitrequest[2]), 32'd0);
    @(posedge clk); #1;
    peek(2, 32'h108, "ab.tb");
    chk("ab.const", tb_readdata[2], 32'h12345678);
    xfer(2, 32'h108, 1'b1, 1'b0, 32'h0, 4'hF, "ab.rd");

    // Random transfers on every instance.
    for (int k = 0; k < int'(NI); k++) begin
      for (int n = 0; n < 25; n++) begin
        a = 32'h200 + {22'h0, 8'($urandom_range(0, 31)), 2'b00};
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 14) == 0) a = 4 * DEPTH + 32'($urandom_range(0, 63)) * 4;
        d   = $urandom;
        sel = $urandom_range(0, 9);
        xfer(k, a, sel >= 5, sel < 5 || sel == 9, d, 4'($urandom_range(0, 15)), "rnd");
      end
    end

    // Error cases.
    xfer(0, 32'h102, 1'b1, 1'b0, 32'h0, 4'hF, "er.mis");
    chk("er.mis.flag", 32'(err[0]), 32'd1);
    xfer(0, 4 * DEPTH, 1'b1, 1'b0, 32'h0, 4'hF, "er.oor");
    xfer(0, 32'h10C, 1'b1, 1'b1, 32'h0BADF00D, 4'hF, "er.rw");
    chk("er.rw.const", tb_readdata[0], 32'h0BADF00D);
    chk("er.sticky", 32'(err[0]), 32'd1);

    // Reset during the last wait state of a write.
    address[0] = 32'h110; write[0] = 1'b1; writedata[0] = 32'hCAFEF00D; byteenable[0] = 4'hF;
    @(negedge clk);
    chk("rw.wr_hi", 32'(waitrequest[0]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; write[0] = 1'b0;
    #1;
    chk("rw.waitreq", 32'(waitrequest[0]), 32'd0);
    chk("rw.err", 32'(err[0]), 32'd0);
    read[0] = 1'b1; address[0] = 32'h100;
    #1;
    chk("rw.req_stall", 32'(waitrequest[0]), 32'd1);
    chk("rw.req_rdata", readdata[0], 32'h0);
    @(posedge clk); #1;
    chk("rw.hold_stall", 32'(waitrequest[0]), 32'd1);
    read[0] = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < int'(NI); k++) err_m[k] = 1'b0;
    @(posedge clk); #1;
    peek(0, 32'h110, "rw.nowrite");
    chk("rw.nowrite.const", tb_readdata[0], 32'h0);
    peek(0, 32'h100, "rw.keep100");
    chk("rw.keep.const", tb_readdata[0], 32'hDEADBEEF);
    xfer(0, 32'h104, 1'b1, 1'b0, 32'h0, 4'hF, "rw.post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
